sha256_round_core: RTL and testbench

SHA256_ROUND_CORE -- requirements
Module: sha256_round_core

---
 rtl/sha256_pkg.sv | 75 +++++++
 rtl/sha256_round_core_if.sv | 32 +++
 rtl/sha256_k_rom.sv | 10 +
 rtl/sha256_round_core.sv | 81 ++++++++
 tb/tb_sha256_round_core.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 shared constants and round helper functions.
// Imported by the round core and its K-constant ROM.
package sha256_pkg;

  localparam int ROUNDS = 64;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_TAB [ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } work_t;

  function automatic logic [31:0] rotr(
    input logic [31:0] x,
    input int unsigned n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] z
  );
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] z
  );
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round_core_if.sv
// Request/status bundle between a message scheduler
// and the SHA-256 round core.
interface sha256_round_core_if;
  logic         start;
  logic [255:0] h_in;
  logic [31:0]  w_in;
  logic [5:0]   round_idx;
  logic         busy;
  logic         done;
  logic [31:0]  a_out;
  logic [31:0]  b_out;
  logic [31:0]  c_out;
  logic [31:0]  d_out;
  logic [31:0]  e_out;
  logic [31:0]  f_out;
  logic [31:0]  g_out;
  logic [31:0]  h_out;

  modport master (
    output start, h_in, w_in,
    input  round_idx, busy, done,
    input  a_out, b_out, c_out, d_out,
    input  e_out, f_out, g_out, h_out
  );

  modport slave (
    input  start, h_in, w_in,
    output round_idx, busy, done,
    output a_out, b_out, c_out, d_out,
    output e_out, f_out, g_out, h_out
  );
endinterface

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 round-constant lookup.
// 6-bit round index in, K[t] out.
import sha256_pkg::*;

module sha256_k_rom (
  input  logic [5:0]  addr,
  output logic [31:0] k
);
  assign k = K_TAB[addr];
endmodule

// File: rtl/sha256_round_core.sv
// Iterative SHA-256 compression core, one round per clock.
// Loads the chaining value on start, runs 64 rounds, pulses done.
import sha256_pkg::*;

module sha256_round_core (
  input logic clk,
  input logic rst_n,
  sha256_round_core_if.slave bus
);

  state_t      st;
  work_t       v;
  work_t       nxt;
  logic [5:0]  idx;
  logic        busy_q;
  logic        done_q;
  logic [31:0] k;
  logic [31:0] t1;
  logic [31:0] t2;

  sha256_k_rom u_k_rom (
    .addr (idx),
    .k    (k)
  );

  always_comb begin
    t1 = v.h + bsig1(v.e) + ch(v.e, v.f, v.g)
       + k + bus.w_in;
    t2 = bsig0(v.a) + maj(v.a, v.b, v.c);
    nxt = '{
      a: t1 + t2, b: v.a, c: v.b, d: v.c,
      e: v.d + t1, f: v.e, g: v.f, h: v.g
    };
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      v      <= work_t'(IV);
      idx    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (st)
        IDLE: begin
          if (bus.start) begin
            v      <= work_t'(bus.h_in);
            idx    <= '0;
            busy_q <= 1'b1;
            st     <= RUN;
          end
        end
        RUN: begin
          // idx wraps 63 -> 0 through its 6-bit width
          v   <= nxt;
          idx <= idx + 6'd1;
          if (idx == 6'(ROUNDS - 1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            st     <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.round_idx = idx;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.a_out     = v.a;
  assign bus.b_out     = v.b;
  assign bus.c_out     = v.c;
  assign bus.d_out     = v.d;
  assign bus.e_out     = v.e;
  assign bus.f_out     = v.f;
  assign bus.g_out     = v.g;
  assign bus.h_out     = v.h;

endmodule

// File: tb/tb_sha256_round_core.sv
// Directed and randomized checks of sha256_round_core
// against a whole-block compression model.
module tb_sha256_round_core;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sha256_round_core_if bus ();

  sha256_round_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] IVT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [255:0] ABC_FINAL = {
    32'h506e3058, 32'hd39a2165, 32'h04d24d6c, 32'hb85e2ce9,
    32'h5ef50f24, 32'hfb121210, 32'h948d25b6, 32'h961f4894
  };

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0] wv [64];

  function automatic logic [31:0] rr(
    input logic [31:0] x,
    input int n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  // Whole-block reference: 64 rounds over an 8-word array.
  function automatic logic [255:0] compress(
    input logic [255:0] hin,
    input int nrounds
  );
    logic [31:0] s [8];
    logic [31:0] x1;
    logic [31:0] x2;
    for (int i = 0; i < 8; i++) s[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < nrounds; t++) begin
      x1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25))
         + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[t] + wv[t];
      x2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22))
         + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      for (int i = 7; i > 0; i--) s[i] = s[i-1];
      s[4] = s[4] + x1;
      s[0] = x1 + x2;
    end
    return {s[0], s[1], s[2], s[3], s[4], s[5], s[6], s[7]};
  endfunction

  task automatic load_abc_schedule();
    for (int t = 0; t < 64; t++) begin
      if (t == 0) wv[t] = 32'h61626380;
      else if (t == 15) wv[t] = 32'h00000018;
      else if (t < 16) wv[t] = 32'h0;
      else
        wv[t] = (rr(wv[t-2], 17) ^ rr(wv[t-2], 19) ^ (wv[t-2] >> 10))
              + wv[t-7]
              + (rr(wv[t-15], 7) ^ rr(wv[t-15], 18) ^ (wv[t-15] >> 3))
              + wv[t-16];
    end
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] outs();
    return {bus.a_out, bus.b_out, bus.c_out, bus.d_out,
            bus.e_out, bus.f_out, bus.g_out, bus.h_out};
  endfunction

  task automatic chk_state(input string tag, input logic [255:0] exp);
    logic [255:0] o;
    o = outs();
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_w%0d", tag, i), o[255 - 32*i -: 32],
          exp[255 - 32*i -: 32]);
  endtask

  // Starts in the current cycle; ends in the done cycle.
  task automatic do_block(
    input string        tag,
    input logic [255:0] hin,
    input int           pulse_t,
    input bit           first_chk,
    input logic [255:0] exp
  );
    bus.start = 1'b1;
    bus.h_in  = hin;
    tick();
    bus.start = 1'b0;
    chk({tag, "_ld"}, 32'(outs() == hin), 32'd1);
    for (int t = 0; t < 64; t++) begin
      bus.w_in  = wv[t];
      bus.start = (t == pulse_t);
      if (t == pulse_t) bus.h_in = ~hin;
      if (first_chk && t == 1) begin
        chk({tag, "_t0_a"}, bus.a_out, 32'h5d6aebcd);
        chk({tag, "_t0_e"}, bus.e_out, 32'hfa2a4622);
        chk({tag, "_t0_f"}, bus.f_out, 32'h510e527f);
        chk({tag, "_t0_g"}, bus.g_out, 32'h9b05688c);
      end
      chk({tag, "_idx"}, 32'(bus.round_idx), t);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_nodone"}, 32'(bus.done), 32'd0);
      tick();
    end
    bus.start = 1'b0;
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    chk({tag, "_wrap"}, 32'(bus.round_idx), 32'd0);
    chk_state({tag, "_res"}, exp);
  endtask

  task automatic idle_ticks(input string tag, input logic [255:0] hold);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_done_lo"}, 32'(bus.done), 32'd0);
      chk({tag, "_idx0"}, 32'(bus.round_idx), 32'd0);
      chk({tag, "_busy_lo"}, 32'(bus.busy), 32'd0);
    end
    chk_state({tag, "_hold"}, hold);
  endtask

  initial begin
    logic [255:0] rh;
    logic [255:0] exp;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.h_in  = '0;
    bus.w_in  = '0;
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_idx", 32'(bus.round_idx), 32'd0);
    chk_state("rst_iv", IVT);
    #3 rst_n = 1'b1;
    tick();

    load_abc_schedule();
    chk("model_abc", 32'(compress(IVT, 64) == ABC_FINAL), 32'd1);

    do_block("abc", IVT, -1, 1'b1, ABC_FINAL);
    chk("abc_h6", bus.f_out + 32'h9b05688c, 32'h96177a9c);
    idle_ticks("abc", ABC_FINAL);

    do_block("ign", IVT, 10, 1'b0, ABC_FINAL);
    idle_ticks("ign", ABC_FINAL);

    do_block("b2b1", IVT, -1, 1'b0, ABC_FINAL);
    do_block("b2b2", IVT, -1, 1'b1, ABC_FINAL);
    idle_ticks("b2b", ABC_FINAL);

    bus.start = 1'b1;
    bus.h_in  = IVT;
    tick();
    bus.start = 1'b0;
    for (int t = 0; t < 20; t++) begin
      bus.w_in = wv[t];
      tick();
    end
    chk("mid_idx20", 32'(bus.round_idx), 32'd20);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_done", 32'(bus.done), 32'd0);
    chk("mid_f", bus.f_out, 32'h9b05688c);
    chk("mid_idx", 32'(bus.round_idx), 32'd0);
    #10 rst_n = 1'b1;
    for (int i = 0; i < 70; i++) begin
      tick();
      chk("mid_no_done", 32'(bus.done), 32'd0);
    end

    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 8; i++) rh[32*i +: 32] = $urandom;
      for (int t = 0; t < 64; t++) wv[t] = $urandom;
      exp = compress(rh, 64);
      do_block($sformatf("rnd%0d", n), rh, -1, 1'b0, exp);
      idle_ticks($sformatf("rnd%0d", n), exp);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
